// File: rtl/divider_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative divider among NUM_REQ requesters.
// Optional watchdog in WAIT enabled by defining DIV_TIMEOUT_EN.
module divider_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rsp_quotient,
  output logic [DATA_WIDTH-1:0]         rsp_remainder,
  output logic                          rsp_overflow,
  output logic                          div_start,
  output logic [DATA_WIDTH-1:0]         div_dividend,
  output logic [DATA_WIDTH-1:0]         div_divisor,
  input  logic [DATA_WIDTH-1:0]         div_quotient,
  input  logic [DATA_WIDTH-1:0]         div_remainder,
  input  logic                          div_overflow,
  input  logic                          div_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("divider_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   pick;
  logic            pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [DATA_WIDTH-1:0] dvd_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] dvs_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] sel_dvd;
  logic [DATA_WIDTH-1:0] sel_dvs;
  logic            expire;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign dvd_arr[k] = req_dividend[k*DATA_WIDTH +: DATA_WIDTH];
    assign dvs_arr[k] = req_divisor[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!pick_valid && req[IW'((32'(last) + i) % NUM_REQ)]) begin
        pick_valid = 1'b1;
        pick       = IW'((32'(last) + i) % NUM_REQ);
      end
    end
  end

  assign sel_dvd     = dvd_arr[pick];
  assign sel_dvs     = dvs_arr[pick];
  assign pick_onehot = NUM_REQ'(1) << pick;
  assign gnt_onehot  = NUM_REQ'(1) << gnt;

`ifdef DIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Held at zero outside WAIT, so it restarts on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + TW'(1);
  end

  assign expire = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= IW'(NUM_REQ - 1);
      gnt           <= '0;
      ack           <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_overflow  <= 1'b0;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      ack       <= '0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt          <= pick;
            div_dividend <= sel_dvd;
            div_divisor  <= sel_dvs;
            busy         <= 1'b1;
            if (sel_dvs == '0) begin
              rsp_quotient  <= '0;
              rsp_remainder <= sel_dvd;
              rsp_overflow  <= 1'b1;
              ack           <= pick_onehot;
              state         <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_overflow  <= div_overflow;
            ack           <= gnt_onehot;
            state         <= RESP;
          end else if (expire) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b1;
            timeout_err   <= 1'b1;
            ack           <= gnt_onehot;
            state         <= RESP;
          end
        end
        RESP: begin
          last  <= gnt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter: requester agents, a behavioural divider and a
// transaction-level round-robin model predicting every grant and response.
module tb_divider_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req;
  logic [NR*DW-1:0]   req_dividend, req_divisor;
  logic [NR-1:0]      ack;
  logic [DW-1:0]      rsp_quotient, rsp_remainder;
  logic               rsp_overflow, div_start;
  logic [DW-1:0]      div_dividend, div_divisor, div_quotient, div_remainder;
  logic               div_overflow, div_done, busy, timeout_err;

  divider_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .ack(ack), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_overflow(rsp_overflow), .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_overflow(div_overflow), .div_done(div_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;
  int cyc = 0;
  bit [NR-1:0] pend, defer;
  int last_m;
  logic [DW-1:0] a_m [NR];
  logic [DW-1:0] b_m [NR];
  int acked_at [NR];
  bit mbusy, mhang, hang_next, stray_en, stray_now;
  int mcnt, lat_force, done_cyc, start_cyc, starts, idle_wait, raise_pct;
  logic [DW-1:0] m_dvd, m_dvs, m_q, m_r;
  bit m_ovf;
  int ack_order[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input bit [NR-1:0] p, input int from);
    for (int i = 1; i <= NR; i++)
      if (p[(from + i) % NR]) return (from + i) % NR;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_divisor();
    case ($urandom_range(7))
      0: return '0;
      1: return 32'd1;
      2: return $urandom;
      default: return $urandom_range(1000, 1);
    endcase
  endfunction

  // Called at a negedge; busy tells whether the coming IDLE sample can include it.
  task automatic raise(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_m[k] = a;
    b_m[k] = b;
    req_dividend[k*DW +: DW] = a;
    req_divisor[k*DW +: DW]  = b;
    req[k] = 1'b1;
    if (busy) defer[k] = 1'b1;
    else      pend[k]  = 1'b1;
  endtask

  task automatic step();
    int g;
    @(negedge clk);
    cyc++;
    if (mbusy) begin
      check("wait_dividend", div_dividend, m_dvd);
      check("wait_divisor", div_divisor, m_dvs);
      check("wait_start_low", div_start, 0);
    end
    if (ack != '0) begin
      g = rr_pick(pend, last_m);
      check("ack_expected", g >= 0, 1);
      if (g >= 0) begin
        ack_order.push_back(g);
        check("ack_vec", ack, NR'(1) << g);
        if (b_m[g] == '0) begin
          check("dbz_quot", rsp_quotient, 0);
          check("dbz_rem", rsp_remainder, a_m[g]);
          check("dbz_ovf", rsp_overflow, 1);
          check("dbz_no_start", starts, 0);
        end else if (mhang) begin
          check("to_quot", rsp_quotient, 0);
          check("to_rem", rsp_remainder, 0);
          check("to_ovf", rsp_overflow, 1);
          check("to_latency", cyc, start_cyc + TO + 1);
          check("to_err", timeout_err, 1);
        end else begin
          check("quot", rsp_quotient, a_m[g] / b_m[g]);
          check("rem", rsp_remainder, a_m[g] % b_m[g]);
          check("ovf", rsp_overflow, m_ovf);
          check("ack_latency", cyc, done_cyc + 1);
          check("one_start", starts, 1);
        end
        req[g] = 1'b0;
        pend[g] = 1'b0;
        acked_at[g] = cyc;
        last_m = g;
      end
      pend |= defer;
      defer = '0;
      starts = 0;
      mhang = 1'b0;
      mbusy = 1'b0;
      idle_wait = 0;
    end else if (pend != '0) begin
      idle_wait++;
      if (idle_wait > 60) begin
        check("progress_watchdog", pend, 0);
        idle_wait = 0;
      end
    end
    // Behavioural divider: responds mcnt cycles after start unless told to hang.
    div_done = 1'b0;
    if (mbusy && !mhang) begin
      if (mcnt <= 1) begin
        div_done = 1'b1;
        div_quotient = m_q;
        div_remainder = m_r;
        div_overflow = m_ovf;
        done_cyc = cyc;
        mbusy = 1'b0;
      end else mcnt--;
    end else if (!mbusy && !busy && (stray_now || (stray_en && $urandom_range(7) == 0))) begin
      div_done = 1'b1;
      div_quotient = $urandom;
      div_remainder = $urandom;
      div_overflow = 1'b1;
      stray_now = 1'b0;
    end
    if (div_start) begin
      g = rr_pick(pend, last_m);
      check("start_expected", g >= 0, 1);
      check("start_overlap", mbusy, 0);
      if (g >= 0) begin
        check("start_dividend", div_dividend, a_m[g]);
        check("start_divisor", div_divisor, b_m[g]);
      end
      starts++;
      start_cyc = cyc;
      mbusy = 1'b1;
      mhang = hang_next;
      mcnt = (lat_force > 0) ? lat_force : $urandom_range(5, 1);
      m_dvd = div_dividend;
      m_dvs = div_divisor;
      m_q = (m_dvs != '0) ? m_dvd / m_dvs : '1;
      m_r = (m_dvs != '0) ? m_dvd % m_dvs : '1;
      m_ovf = 1'($urandom_range(1));
    end
    if (raise_pct > 0 && ack == '0)
      for (int k = 0; k < NR; k++)
        if (!req[k] && cyc > acked_at[k] + 1 && $urandom_range(99) < raise_pct)
          raise(k, ($urandom_range(1) != 0) ? $urandom : $urandom_range(5000), rand_divisor());
  endtask

  task automatic drain();
    int n = 0;
    while (((pend | defer) != '0 || busy) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", pend | defer, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req = '0;
    div_done = 1'b0;
    pend = '0;
    defer = '0;
    mbusy = 1'b0;
    mhang = 1'b0;
    starts = 0;
    idle_wait = 0;
    repeat (n) @(negedge clk);
    cyc += n;
    check("rst_ack", ack, 0);
    check("rst_quot", rsp_quotient, 0);
    check("rst_rem", rsp_remainder, 0);
    check("rst_ovf", rsp_overflow, 0);
    check("rst_start", div_start, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_divisor", div_divisor, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    last_m = NR - 1;
  endtask

  initial begin
    int exp_ord [6] = '{0, 1, 2, 3, 0, 1};
    int n;
    req = '0; req_dividend = '0; req_divisor = '0;
    div_quotient = '0; div_remainder = '0; div_overflow = 1'b0; div_done = 1'b0;
    raise_pct = 0; lat_force = 0; stray_en = 1'b0; stray_now = 1'b0; hang_next = 1'b0;
    for (int k = 0; k < NR; k++) acked_at[k] = -10;
    do_reset(3);

    // Single request: 1024000 / 250, divider answers 5 cycles after start.
    raise(0, 32'd1024000, 32'd250);
    lat_force = 5;
    step();
    check("single_start_latency", div_start, 1);
    drain();
    check("single_quotient", rsp_quotient, 4096);
    lat_force = 0;

    // Divide by zero: ack on the cycle after the request is sampled.
    raise(2, 32'd77, 32'd0);
    step();
    check("dbz_latency", ack, 4'b0100);
    drain();

    // Fairness with every requester re-raising after its ack.
    do_reset(1);
    ack_order.delete();
    raise_pct = 100;
    n = 0;
    while (ack_order.size() < 6 && n < 300) begin step(); n++; end
    raise_pct = 0;
    check("rr_count", ack_order.size(), 6);
    for (int i = 0; i < 6 && i < ack_order.size(); i++) check("rr_order", ack_order[i], exp_ord[i]);
    drain();

    // Late arrival of requester 3 while requester 1 is being served.
    raise(1, 32'd99999, 32'd1000);
    lat_force = 6;
    n = 0;
    while (!mbusy && n < 10) begin step(); n++; end
    raise(3, 32'd12345, 32'd7);
    n = 0;
    while (ack == '0 && n < 20) begin step(); n++; end
    check("late_ack1", ack, 4'b0010);
    step();
    step();
    check("late_start", div_start, 1);
    check("late_dividend", div_dividend, 12345);
    drain();

    // Reset during WAIT followed by a stray done.
    lat_force = 8;
    raise(1, 32'd5000, 32'd3);
    n = 0;
    while (!mbusy && n < 10) begin step(); n++; end
    step();
    do_reset(1);
    lat_force = 0;
    step();
    stray_now = 1'b1;
    step();
    repeat (3) begin
      step();
      check("stray_no_ack", ack, 0);
      check("stray_idle", busy, 0);
    end
    raise(1, 32'd4242, 32'd2);
    raise(3, 32'd3333, 32'd3);
    step();
    check("post_rst_grant", div_dividend, 4242);
    drain();

    // Randomized traffic with stray dones sprinkled into IDLE.
    stray_en = 1'b1;
    raise_pct = 20;
    repeat (2500) step();
    raise_pct = 0;
    drain();
    stray_en = 1'b0;

`ifdef DIV_TIMEOUT_EN
    hang_next = 1'b1;
    raise(0, 32'd500, 32'd5);
    drain();
    hang_next = 1'b0;
    repeat (3) begin
      step();
      check("timeout_sticky", timeout_err, 1);
    end
    do_reset(1);
`else
    check("timeout_err_tied", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
